// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 VGA timing constants shared by the sync generator and scan-out logic.
package vga_timing_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_LAST = H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_LAST = V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1;
endpackage

// File: rtl/xy_point_scanout_if.sv
// xy_point_scanout_if: point producer handshake, commit request and write-bank status.
interface xy_point_scanout_if #(parameter int DEPTH = 16);
  logic pt_valid;
  logic pt_ready;
  logic [9:0] pt_x;
  logic [9:0] pt_y;
  logic commit;
  logic swap_pending;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master(output pt_valid, pt_x, pt_y, commit, input pt_ready, swap_pending, count);
  modport slave(input pt_valid, pt_x, pt_y, commit, output pt_ready, swap_pending, count);
endinterface

// File: rtl/point_match_bank.sv
// point_match_bank: DEPTH-entry (x,y) store with fill count and combinational beam-position hit.
module point_match_bank #(parameter int DEPTH = 16) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic wr,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic hit
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [9:0] xs [DEPTH];
  logic [9:0] ys [DEPTH];
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (wr) count <= count + 1'b1;
  end
  // entries are qualified by count, so storage needs no reset
  always_ff @(posedge clk) begin
    if (wr) begin
      xs[count[AW-1:0]] <= x;
      ys[count[AW-1:0]] <= y;
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (CW'(i) < count && xs[i] == hpos && ys[i] == vpos);
  end
endmodule

// File: rtl/xy_point_scanout.sv
// xy_point_scanout: double-buffered point list scanned against the beam, swapped only at frame end.
module xy_point_scanout #(
  parameter int DEPTH = 16,
  parameter int H_LAST = vga_timing_pkg::H_LAST,
  parameter int V_LAST = vga_timing_pkg::V_LAST
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic display_on,
  xy_point_scanout_if.slave pts,
  output logic pixel_on
);
  localparam int CW = $clog2(DEPTH+1);
  logic sel;
  logic boundary;
  logic swap;
  logic accept;
  logic [CW-1:0] cnt [2];
  logic [1:0] hit;
  assign boundary = en && hpos == 10'(H_LAST) && vpos == 10'(V_LAST);
  assign swap = boundary && pts.swap_pending;
  assign accept = pts.pt_valid && pts.pt_ready;
  assign pts.pt_ready = cnt[sel] < CW'(DEPTH) && !pts.swap_pending;
  assign pts.count = cnt[sel];
  // sel names the write bank; the other one drives the match
  for (genvar b = 0; b < 2; b++) begin : g_bank
    point_match_bank #(.DEPTH(DEPTH)) u_bank (
      .clk(clk),
      .reset(reset),
      .clr(swap && sel != 1'(b)),
      .wr(accept && sel == 1'(b)),
      .x(pts.pt_x),
      .y(pts.pt_y),
      .hpos(hpos),
      .vpos(vpos),
      .count(cnt[b]),
      .hit(hit[b])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= 1'b0;
      pts.swap_pending <= 1'b0;
      pixel_on <= 1'b0;
    end else begin
      if (swap) begin
        sel <= ~sel;
        pts.swap_pending <= 1'b0;
      end else if (pts.commit) pts.swap_pending <= 1'b1;
      if (en) pixel_on <= display_on && hit[~sel];
    end
  end
endmodule

// File: tb/tb_xy_point_scanout.sv
// tb_xy_point_scanout: directed and random stimulus checked against a queue-based frame model.
module tb_xy_point_scanout;
  localparam int DEPTH = 16;
  localparam int HL = 49;
  localparam int VL = 29;
  localparam int HV = 40;
  localparam int VV = 24;
  localparam int FRAME = (HL + 1) * (VL + 1);
  logic clk = 1'b0;
  logic reset, en, display_on, pixel_on;
  logic [9:0] hpos, vpos;
  xy_point_scanout_if #(.DEPTH(DEPTH)) pts();
  xy_point_scanout #(.DEPTH(DEPTH), .H_LAST(HL), .V_LAST(VL)) dut (
    .clk(clk), .reset(reset), .en(en), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .pts(pts), .pixel_on(pixel_on)
  );
  always #5 clk = ~clk;
  logic [19:0] wq [$];
  logic [19:0] dq [$];
  bit m_pend, m_pix;
  int h, vv, n_tests, n_fail, ones;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", tag, got, exp, h, vv);
    end
  endtask
  task automatic step(input logic r, input logic v, input int x, input int y, input logic c, input logic e);
    bit hit, rdy, bnd, don;
    reset = r; en = e; pts.pt_valid = v; pts.pt_x = 10'(x); pts.pt_y = 10'(y); pts.commit = c;
    hpos = 10'(h); vpos = 10'(vv);
    don = h < HV && vv < VV;
    display_on = don;
    #1;
    rdy = wq.size() < DEPTH && !m_pend;
    if (!r) chk("ready", int'(pts.pt_ready), int'(rdy));
    hit = 0;
    foreach (dq[i]) if (dq[i] == {10'(h), 10'(vv)}) hit = 1;
    bnd = e && h == HL && vv == VL;
    if (r) begin
      wq.delete(); dq.delete(); m_pend = 0; m_pix = 0;
    end else begin
      if (v && rdy) wq.push_back({10'(x), 10'(y)});
      if (bnd && m_pend) begin
        dq = wq; wq.delete(); m_pend = 0;
      end else if (c) m_pend = 1;
      if (e) m_pix = don && hit;
    end
    if (e) begin
      if (h == HL) begin
        h = 0; vv = (vv == VL) ? 0 : vv + 1;
      end else h = h + 1;
    end
    @(posedge clk); #1;
    chk("count", int'(pts.count), wq.size());
    chk("swap_pending", int'(pts.swap_pending), int'(m_pend));
    chk("pixel_on", int'(pixel_on), int'(m_pix));
    ones += int'(pixel_on);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 1);
  endtask
  task automatic push(input int x, input int y, input logic c);
    step(0, 1, x, y, c, 1);
  endtask
  task automatic to_boundary();
    int k = 0;
    while (!(h == HL && vv == VL) && k < 2 * FRAME) begin
      idle(1); k++;
    end
    chk("boundary_reached", k < 2 * FRAME ? 1 : 0, 1);
    idle(1);
  endtask
  task automatic frame_ones(output int n);
    ones = 0;
    idle(FRAME);
    n = ones;
  endtask
  initial begin
    int n, k;
    h = 0; vv = 0; n_tests = 0; n_fail = 0; ones = 0;
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 3, 3, 1, 1);
    chk("reset_ready", int'(pts.pt_ready), 1);
    // single point, one hit per frame
    push(10, 5, 0);
    step(0, 0, 0, 0, 1, 1);
    to_boundary();
    frame_ones(n);
    chk("single_hit_frame", n, 1);
    // fill with valid held; the 17th is refused
    for (int i = 0; i < DEPTH + 1; i++) push($urandom_range(0, HV - 1), $urandom_range(0, VV - 1), 0);
    chk("full_count", int'(pts.count), DEPTH);
    chk("full_ready", int'(pts.pt_ready), 0);
    step(0, 0, 0, 0, 1, 1);
    to_boundary();
    idle(FRAME);
    // mid-frame commit blocks acceptance until frame end
    for (int i = 0; i < 3; i++) push($urandom_range(0, HV - 1), $urandom_range(0, VV - 1), 0);
    k = 0;
    while (vv != 12 && k < 2 * FRAME) begin idle(1); k++; end
    step(0, 0, 0, 0, 1, 1);
    chk("mid_pending", int'(pts.swap_pending), 1);
    chk("mid_ready", int'(pts.pt_ready), 0);
    push(7, 7, 1);
    to_boundary();
    chk("post_swap_count", int'(pts.count), 0);
    chk("post_swap_ready", int'(pts.pt_ready), 1);
    idle(FRAME);
    // point in horizontal blanking never lights
    push(45, 5, 1);
    to_boundary();
    frame_ones(n);
    chk("blank_hits", n, 0);
    // en toggling over a matched pixel
    push(20, 3, 1);
    to_boundary();
    for (int i = 0; i < 2 * FRAME; i++) step(0, 0, 0, 0, 0, i % 2 == 0);
    // empty commit blanks the display
    step(0, 0, 0, 0, 1, 1);
    to_boundary();
    frame_ones(n);
    chk("empty_commit_hits", n, 0);
    // reset while a swap is pending
    push(12, 4, 0);
    push(30, 9, 1);
    idle(1);
    step(1, 1, 5, 5, 1, 1);
    chk("rst_pending", int'(pts.swap_pending), 0);
    chk("rst_count", int'(pts.count), 0);
    to_boundary();
    frame_ones(n);
    chk("rst_blank_hits", n, 0);
    // random traffic, including en low across the boundary position
    for (int i = 0; i < 12000; i++)
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, HL), $urandom_range(0, VL),
           $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
